regfile_sb: RTL

Parametrised multi-port integer register file with same-cycle write-to-read bypass and an integrated busy-bit scoreboard. It replaces the fixed two-slot register file in the issue/writeback path of the dual-issue core. It scales to NW write ports and NR read ports. Decode allocates destinations (sets busy); writeback both commits data and clears busy; a flush input drops all outstanding allocations.

---
 rtl/regfile_sb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Multi-port integer register file with same-cycle write-to-read bypass and a
// busy-bit scoreboard. Decode allocates destinations, writeback commits data and clears busy.
module regfile_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NW     = 2,
    parameter int unsigned NR     = 4,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NW-1:0]        we,
    input  logic [NW*AW-1:0]     waddr,
    input  logic [NW*XLEN-1:0]   wdata,
    input  logic [NW-1:0]        alloc,
    input  logic [NW*AW-1:0]     alloc_addr,
    input  logic                 flush,
    input  logic [NR*AW-1:0]     raddr,
    output logic [NR*XLEN-1:0]   rdata,
    output logic [NR-1:0]        rready,
    output logic [AW:0]          busy_cnt
);

    logic [AW-1:0]   wa [NW];
    logic [XLEN-1:0] wd [NW];
    logic [AW-1:0]   aa [NW];
    logic [AW-1:0]   ra [NR];

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] alloc_hit;
    logic [NREG-1:0] wb_hit;

    logic [AW:0]     cnt_d;
    logic [AW:0]     cnt_q;

    logic [NR-1:0]   byp_hit;
    logic [XLEN-1:0] rd_val [NR];

    always_comb begin
        for (int unsigned i = 0; i < NW; i++) begin
            wa[i] = waddr[i*AW +: AW];
            wd[i] = wdata[i*XLEN +: XLEN];
            aa[i] = alloc_addr[i*AW +: AW];
        end
        for (int unsigned j = 0; j < NR; j++) begin
            ra[j] = raddr[j*AW +: AW];
        end
    end

    // Ascending port order makes the highest-index (youngest) writer win.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < NW; i++) begin
            if (we[i] && (wa[i] != '0)) begin
                regs_d[wa[i]] = wd[i];
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        alloc_hit = '0;
        wb_hit    = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            if (alloc[i]) begin
                alloc_hit[aa[i]] = 1'b1;
            end
            if (we[i]) begin
                wb_hit[wa[i]] = 1'b1;
            end
        end
    end

    // Flush beats alloc, and a fresh alloc beats a same-cycle writeback clear.
    always_comb begin
        busy_d    = flush ? '0 : (alloc_hit | (busy_q & ~wb_hit));
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    always_comb begin
        byp_hit = '0;
        rdata   = '0;
        rready  = '0;
        for (int unsigned j = 0; j < NR; j++) begin
            rd_val[j] = regs_q[ra[j]];
            for (int unsigned i = 0; i < NW; i++) begin
                if ((BYPASS != 0) && we[i] && (wa[i] == ra[j])) begin
                    rd_val[j]  = wd[i];
                    byp_hit[j] = 1'b1;
                end
            end
            if (ra[j] == '0) begin
                rd_val[j]  = '0;
                byp_hit[j] = 1'b0;
            end
            rdata[j*XLEN +: XLEN] = rd_val[j];
            rready[j] = (ra[j] == '0) || !busy_q[ra[j]] || byp_hit[j];
        end
    end

    // Decode must not re-allocate a pending register unless it is being written back now.
    for (genvar gi = 0; gi < NW; gi++) begin : g_waw_chk
        a_no_waw: assert property (@(posedge clk) disable iff (rst)
            (alloc[gi] && !flush && (aa[gi] != '0) && busy_q[aa[gi]]) |-> wb_hit[aa[gi]]);
    end

endmodule
